boot_stub: RTL
==============

# boot_stub

Parametrised reset-vector injector for the CPU fetch path. After reset, or on a software re-arm, it drives a configurable instruction stream (optional NOP preamble, JMP opcode, little-endian target address) in response to successive CPU read strobes. It then deasserts `valid` so the bus mux hands fetches back to normal memory.

## Interface
- `NOP_COUNT`, 0: number of NOP bytes emitted before the JMP opcode (0..4)
- `NOP_OPCODE`, 8'h00: byte used for the preamble
- `JMP_OPCODE`, 8'hC3: absolute-jump opcode byte
- `ADDR_W`, 16: jump address width; multiple of 8, range 8..32
- `BOOT_ADDR`, 16'hFD00: jump target when the address-input feature is compiled out
- `clk  in  1`: clock
- `reset  in  1`: synchronous, active-high; overrides everything
- `rd  in  1`: CPU read strobe; level signal, only rising edges count
- `rearm  in  1`: one-cycle request to restart the stream
- `boot_addr_in  in  ADDR_W`: runtime jump target (present only with `BOOT_STUB_ADDR_IN_EN`)
- `data_out  out  8`: byte presented to the CPU
- `valid  out  1`: high while the stub owns the fetch bus
- `done  out  1`: one-cycle pulse on the cycle `valid` falls

## Operation
- Stream length `LEN = NOP_COUNT + 1 + ADDR_W/8`.
- Byte order: index 0..NOP_COUNT-1 is `NOP_OPCODE`, index NOP_COUNT is `JMP_OPCODE`, then address bytes LSB first.
- Internal regs: `idx` (width clog2(LEN+1)), `prev_rd`, `tgt` (latched ADDR_W target), and a 2-bit state.
- Edge detect: `edge = rd & ~prev_rd`; `prev_rd <= rd` every non-reset cycle.
- States:
  - EMIT: `valid=1`. On `edge`: `data_out <= byte[idx]`, `idx <= idx+1`. Go to FINAL when the new `idx == LEN`.
  - FINAL: `valid=1`; all bytes have been presented. On `edge`: `valid <= 0`, `done <= 1`, go to IDLE. `data_out` holds its last byte.
  - IDLE: `valid=0`; `rd` is ignored.
- `rearm` in any state: `idx <= 0`, `valid <= 1`, state <= EMIT, `tgt` re-latched. A coincident `edge` is discarded, so `rearm` wins.
- Reset values: state EMIT, `idx=0`, `prev_rd=0`, `data_out=8'h00`, `valid=1`, `done=0`, `tgt` latched.
- If `rd` is high on the first cycle after reset, it counts as an edge because `prev_rd` resets to 0.
- A reset mid-stream restarts from index 0. No partial state survives reset.

## Timing
- An edge sampled at clock edge t produces the new `data_out` after edge t, so the byte is valid from cycle t+1. Latency is 1 cycle.
- `rd` must be low for at least 1 cycle between reads. A level held high advances exactly one byte.
- `valid` falls on the cycle after the release edge. `done` is high for that single cycle only.
- `done` is a registered pulse and clears on the next cycle unconditionally.
- No combinational path from `rd` to any output.

## Configuration
- `BOOT_STUB_ADDR_IN_EN` defined:
  - Port `boot_addr_in` exists.
  - `tgt` captures it on the reset cycle and on each `rearm` cycle.
  - Later changes to `boot_addr_in` do not affect a stream in progress.
- `BOOT_STUB_ADDR_IN_EN` undefined:
  - No port.
  - `tgt` is the constant `BOOT_ADDR[ADDR_W-1:0]`.

## Test plan
- Defaults, reset, then 4 rd pulses -> `data_out` sequence C3, 00, FD, then `valid` drops 1 cycle after the 4th pulse. `done` pulses once; `data_out` stays FD.
- `NOP_COUNT=2`, `ADDR_W=24`, `BOOT_ADDR=24'h12_3456` -> sequence 00, 00, C3, 56, 34, 12, then `valid` low after the 7th pulse.
- `rd` held high for 10 cycles after reset -> exactly one advance: `data_out=C3`, `idx=1`.
- `rearm` asserted together with a rd edge mid-stream (after byte 00) -> edge ignored. The next pulse yields C3 again and `valid` stays 1.
- With `BOOT_STUB_ADDR_IN_EN`: `boot_addr_in=16'hA55A` at reset, changed to 16'h0000 mid-stream -> address bytes 5A, A5. After IDLE, `rearm` with input 16'hBEEF -> C3, EF, BE.
- Reset asserted after 2 bytes -> `data_out=00`, `valid=1`, `done=0`. The next pulse yields C3.

Source files
------------

// File: rtl/boot_stub.sv
// Purpose : reset-vector injector; feeds [NOP preamble, JMP opcode, LE target] to CPU fetches.
// Latency : 1 cycle from a sampled rd rising edge to the new data_out byte.
// Backpressure: none; advances only on rd rising edges, owns the bus while valid is high.
// Optional feature macro: BOOT_STUB_ADDR_IN_EN (adds runtime boot_addr_in jump target).

module boot_stub #(
    parameter int unsigned NOP_COUNT  = 0,
    parameter logic [7:0]  NOP_OPCODE = 8'h00,
    parameter logic [7:0]  JMP_OPCODE = 8'hC3,
    parameter int unsigned ADDR_W     = 16,
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_FD00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              rearm,
`ifdef BOOT_STUB_ADDR_IN_EN
    input  logic [ADDR_W-1:0] boot_addr_in,
`endif
    output logic [7:0]        data_out,
    output logic              valid,
    output logic              done
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int unsigned ADDR_BYTES = ADDR_W / 8;
    localparam int unsigned LEN        = NOP_COUNT + 1 + ADDR_BYTES;
    localparam int unsigned IDX_W      = $clog2(LEN + 1);

    localparam logic [IDX_W-1:0] LEN_IDX = IDX_W'(LEN);
    localparam logic [IDX_W-1:0] JMP_IDX = IDX_W'(NOP_COUNT);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    // Reject configurations the byte selector cannot represent.
    if (NOP_COUNT > 4) begin : g_bad_nop
        $error("boot_stub: NOP_COUNT must be in 0..4");
    end
    if ((ADDR_W % 8) != 0 || ADDR_W < 8 || ADDR_W > 32) begin : g_bad_addr
        $error("boot_stub: ADDR_W must be a multiple of 8 in 8..32");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // EMIT  : bytes still to present
    // FINAL : last byte is on the bus, next read hands the bus back
    // IDLE  : bus released, rd ignored until rearm/reset
    typedef enum logic [1:0] {
        S_EMIT  = 2'd0,
        S_FINAL = 2'd1,
        S_IDLE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             prev_rd_q;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [ADDR_W-1:0] tgt;
    logic             rd_rise;
    logic [7:0]       cur_byte;
    logic [IDX_W-1:0] idx_inc;

    // ------------------------------------------------------------------
    // Jump target
    // ------------------------------------------------------------------
`ifdef BOOT_STUB_ADDR_IN_EN
    logic [ADDR_W-1:0] tgt_q;

    // Snapshot the runtime target at reset and rearm so a stream in flight
    // never sees a half-changed address.
    always_ff @(posedge clk) begin
        if (reset || rearm) begin
            tgt_q <= boot_addr_in;
        end
    end

    assign tgt = tgt_q;
`else
    assign tgt = BOOT_ADDR[ADDR_W-1:0];
`endif

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    assign rd_rise = rd & ~prev_rd_q;
    assign idx_inc = idx_q + IDX_ONE;

    // Byte at the current index: NOP preamble, then opcode, then target LSB first.
    always_comb begin
        cur_byte = NOP_OPCODE;
        if (idx_q == JMP_IDX) begin
            cur_byte = JMP_OPCODE;
        end
        for (int b = 0; b < int'(ADDR_BYTES); b++) begin
            if (idx_q == IDX_W'(int'(NOP_COUNT) + 1 + b)) begin
                cur_byte = tgt[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // Rearm outranks any coincident read edge; done is a single-cycle pulse.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        if (rearm) begin
            state_d = S_EMIT;
            idx_d   = '0;
            valid_d = 1'b1;
        end else begin
            case (state_q)
                S_EMIT: begin
                    valid_d = 1'b1;
                    if (rd_rise) begin
                        data_d = cur_byte;
                        idx_d  = idx_inc;
                        if (idx_inc == LEN_IDX) begin
                            state_d = S_FINAL;
                        end
                    end
                end
                S_FINAL: begin
                    if (rd_rise) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_IDLE: begin
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = S_EMIT;
                    idx_d   = '0;
                    valid_d = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Reset restarts the stream from index 0 with the stub owning the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_EMIT;
            idx_q     <= '0;
            prev_rd_q <= 1'b0;
            data_q    <= 8'h00;
            valid_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            prev_rd_q <= rd;
            data_q    <= data_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign done     = done_q;

endmodule
